// File: rtl/bus_response_collector.sv
`default_nettype none
// ============================================================================
// Module   : bus_response_collector
// Purpose  : Return path of the CPU data bus. It latches the one-hot device
//            select produced by the address decoder and waits for the selected
//            peripheral to complete. It then hands that device's read data back
//            to the CPU with a single registered done pulse. Unmapped
//            addresses, multi-hit decodes and silent devices become bus errors,
//            so the CPU can never hang on a transaction.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req        one-cycle CPU request strobe
//   i_sel        decoder device-select vector (sampled with i_req in IDLE)
//   i_dev_done   per-device completion pulse
//   i_dev_rdata  per-device read data, device k at [k*DATA_W +: DATA_W]
//   o_busy       transaction in flight (valid decode accepted until done)
//   o_done       one-cycle completion pulse
//   o_rdata      read data, valid with o_done, held until the next response
//   o_error      transaction failed (qualifies o_done)
//   o_err_code   00 ok, 01 unmapped, 10 multi-hit, 11 timeout
//   o_req_drop   one-cycle pulse when a request arrives while not idle
// ============================================================================
module bus_response_collector #(
  parameter int NUM_DEV        = 13,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req,
  input  logic [NUM_DEV-1:0]        i_sel,
  input  logic [NUM_DEV-1:0]        i_dev_done,
  input  logic [NUM_DEV*DATA_W-1:0] i_dev_rdata,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_error,
  output logic [1:0]                o_err_code,
  output logic                      o_req_drop
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_MULTI    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_DEV-1:0] SEL_ONE  = NUM_DEV'(1);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [NUM_DEV-1:0] sel_q;
  logic [CNT_W-1:0]   cnt;
  logic               sel_none;
  logic               sel_single;
  logic               accept;
  logic               dev_hit;
  logic               timeout;
  logic [DATA_W-1:0]  sel_rdata;
  logic [1:0]         code_nxt;
  logic [DATA_W-1:0]  rdata_nxt;
  logic               busy_nxt;

  // x & (x-1) clears the lowest set bit, so a zero result on a non-zero
  // vector means exactly one device was decoded.
  assign sel_none   = (i_sel == '0);
  assign sel_single = !sel_none && ((i_sel & (i_sel - SEL_ONE)) == '0);
  assign accept     = (state == ST_IDLE) && i_req && sel_single;

  // Masking with the latched select makes stray completions from other
  // devices invisible.
  assign dev_hit = |(i_dev_done & sel_q);
  assign timeout = (cnt == CNT_LAST);

  // AND-OR mux; the latched select is one-hot so at most one slice survives.
  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      sel_rdata = sel_rdata | ({DATA_W{sel_q[k]}} & i_dev_rdata[k*DATA_W +: DATA_W]);
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; code_nxt is the completion code carried into RESP.
  always_comb begin
    state_nxt = state;
    code_nxt  = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (i_req) begin
          if (sel_none) begin
            state_nxt = ST_RESP;
            code_nxt  = ERR_UNMAPPED;
          end else if (!sel_single) begin
            state_nxt = ST_RESP;
            code_nxt  = ERR_MULTI;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // A completion in the last counted cycle still wins over the timeout.
        if (dev_hit) begin
          state_nxt = ST_RESP;
          code_nxt  = ERR_NONE;
        end else if (timeout) begin
          state_nxt = ST_RESP;
          code_nxt  = ERR_TIMEOUT;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    // WAIT always leads to WAIT or RESP, both of which count as busy.
    busy_nxt  = accept || (state == ST_WAIT);
    rdata_nxt = ((state == ST_WAIT) && dev_hit) ? sel_rdata : '0;
  end

  // Latched select and WAIT-cycle counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_q <= '0;
      cnt   <= '0;
    end else if (accept) begin
      sel_q <= i_sel;
      cnt   <= '0;
    end else if (state == ST_WAIT) begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Registered outputs; response fields only change when entering RESP so
  // the read data stays stable between transactions.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rdata    <= '0;
      o_error    <= 1'b0;
      o_err_code <= ERR_NONE;
      o_req_drop <= 1'b0;
    end else begin
      o_busy     <= busy_nxt;
      o_done     <= (state_nxt == ST_RESP);
      o_req_drop <= i_req && (state != ST_IDLE);
      if (state_nxt == ST_RESP) begin
        o_rdata    <= rdata_nxt;
        o_err_code <= code_nxt;
        o_error    <= (code_nxt != ERR_NONE);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_response_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_response_collector
// Purpose  : Self-checking bench for bus_response_collector. Directed
//            scenarios followed by randomized transactions, each compared
//            against a transaction-level reference model of the response rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_response_collector;

  localparam int NUM_DEV = 13;
  localparam int DATA_W  = 32;
  localparam int T       = 16;
  localparam int CNT_W   = 11;

  logic                      clk;
  logic                      rst_n;
  logic                      i_req;
  logic [NUM_DEV-1:0]        i_sel;
  logic [NUM_DEV-1:0]        i_dev_done;
  logic [NUM_DEV*DATA_W-1:0] i_dev_rdata;
  logic                      o_busy;
  logic                      o_done;
  logic [DATA_W-1:0]         o_rdata;
  logic                      o_error;
  logic [1:0]                o_err_code;
  logic                      o_req_drop;

  int checks = 0;
  int errors = 0;

  bus_response_collector #(
    .NUM_DEV        (NUM_DEV),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (T),
    .CNT_W          (CNT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (i_req),
    .i_sel       (i_sel),
    .i_dev_done  (i_dev_done),
    .i_dev_rdata (i_dev_rdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_error     (o_error),
    .o_err_code  (o_err_code),
    .o_req_drop  (o_req_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic randomize_rdata();
    for (int k = 0; k < NUM_DEV; k++) begin
      i_dev_rdata[k*DATA_W +: DATA_W] = $urandom;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},     o_busy,     0);
    chk({tag, "_done"},     o_done,     0);
    chk({tag, "_rdata"},    o_rdata,    0);
    chk({tag, "_error"},    o_error,    0);
    chk({tag, "_err_code"}, o_err_code, 0);
    chk({tag, "_req_drop"}, o_req_drop, 0);
  endtask

  // One complete transaction, entered and left at a falling edge.
  // Reference model: decode by population count, then the device answers
  // after 'delay' WAIT cycles if that fits inside the timeout window,
  // otherwise the timeout fires after T WAIT cycles. o_done appears one
  // cycle after the deciding cycle. drop_s < 0 picks a random stray-request
  // step inside the transaction; 0 means none.
  task automatic run_txn(input logic [NUM_DEV-1:0] sel, input int delay,
                         input logic [31:0] data, input int drop_s,
                         input logic [NUM_DEV-1:0] extra);
    int          pc;
    int          idx;
    int          d_end;
    logic        ok_path;
    logic        err_path;
    logic [1:0]  exp_code;
    logic [31:0] exp_rd;
    pc       = $countones(sel);
    idx      = 0;
    ok_path  = 1'b0;
    err_path = 1'b0;
    exp_rd   = '0;
    for (int k = 0; k < NUM_DEV; k++) if (sel[k]) idx = k;
    if (pc == 0) begin
      err_path = 1'b1; exp_code = 2'b01; d_end = 1;
    end else if (pc > 1) begin
      err_path = 1'b1; exp_code = 2'b10; d_end = 1;
    end else if (delay >= 1 && delay <= T) begin
      ok_path = 1'b1; exp_code = 2'b00; exp_rd = data; d_end = delay + 1;
    end else begin
      exp_code = 2'b11; exp_rd = '0; d_end = T + 1;
    end
    if (drop_s < 0) drop_s = $urandom_range(1, d_end);

    i_req      = 1'b1;
    i_sel      = sel;
    i_dev_done = NUM_DEV'($urandom) & ~sel;
    randomize_rdata();

    for (int s = 1; s <= d_end + 1; s++) begin
      @(negedge clk);
      chk("done",     o_done,     (s == d_end));
      chk("busy",     o_busy,     (!err_path && s <= d_end));
      chk("req_drop", o_req_drop, (drop_s != 0 && s == drop_s + 1));
      if (s == d_end) begin
        chk("error",    o_error,    (exp_code != 2'b00));
        chk("err_code", o_err_code, exp_code);
        if (!err_path) chk("rdata", o_rdata, exp_rd);
      end
      if (s == d_end + 1 && !err_path) chk("rdata_hold", o_rdata, exp_rd);

      i_req      = (s == drop_s);
      i_sel      = NUM_DEV'($urandom);
      i_dev_done = (NUM_DEV'($urandom) | extra) & ~sel;
      randomize_rdata();
      if (ok_path && s == delay) begin
        i_dev_done = i_dev_done | sel;
        i_dev_rdata[idx*DATA_W +: DATA_W] = data;
      end
      if (s == d_end + 1) begin
        i_req      = 1'b0;
        i_dev_done = '0;
      end
    end
  endtask

  initial begin
    int          kind;
    int          a;
    int          b;
    logic [12:0] sel;

    rst_n       = 1'b0;
    i_req       = 1'b0;
    i_sel       = '0;
    i_dev_done  = '0;
    i_dev_rdata = '0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios
    run_txn(13'h0002, 3, 32'hDEADBEEF, 0, 13'h0);   // sdram read
    run_txn(13'h0000, 0, 32'h0, 0, 13'h0);          // unmapped
    run_txn(13'h0204, 0, 32'h0, 0, 13'h0);          // multi-hit
    run_txn(13'h0200, 0, 32'h0, 0, 13'h0008);       // uart timeout, ps2 noise
    run_txn(13'h0010, 5, 32'h12345678, 2, 13'h0);   // stray request mid-WAIT
    run_txn(13'h1000, T, 32'hA5A5A5A5, 0, 13'h0);   // answer in the last cycle
    run_txn(13'h0001, 1, 32'h0BADF00D, 2, 13'h0);   // stray request in RESP

    // Reset in the middle of a plic transaction
    i_req = 1'b1;
    i_sel = 13'h0400;
    @(negedge clk);
    i_req = 1'b0;
    @(negedge clk);
    #3;
    rst_n      = 1'b0;
    i_dev_done = 13'h0400;
    i_dev_rdata[10*DATA_W +: DATA_W] = 32'hFFFF0000;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    chk("rst_hold_done", o_done, 0);
    chk("rst_hold_busy", o_busy, 0);
    i_dev_done = '0;
    rst_n = 1'b1;
    run_txn(13'h0400, 2, 32'h00000007, 0, 13'h0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        sel = '0;
      end else if (kind == 1) begin
        a   = $urandom_range(0, 12);
        b   = (a + $urandom_range(1, 12)) % 13;
        sel = (13'h1 << a) | (13'h1 << b);
      end else begin
        sel = 13'h1 << $urandom_range(0, 12);
      end
      run_txn(sel, $urandom_range(1, 20), $urandom,
              ($urandom_range(0, 2) == 0) ? -1 : 0, 13'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
